// File: rtl/vx_scb_issue_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vx_scb_issue_arb
//
// Scoreboarded issue arbiter. Several warp requesters compete for a single
// issue slot. Each requester has a table of busy bits, one per architectural
// register. A requester may issue only when none of its four operand
// registers (rd, rs1, rs2, rs3) is busy. Among the eligible requesters a
// round-robin pointer picks the winner. The winner's payload is captured in a
// one-entry output register. If the instruction writes rd, the busy bit for
// that register is set. A writeback with end-of-packet clears the busy bit
// again.
//
// Ports
//   clk          : sole clock, rising edge
//   reset        : asynchronous, active-high
//   req_valid    : [NUM_REQS]          per-requester instruction valid
//   req_ready    : [NUM_REQS]          per-requester accept, one-hot or zero
//   req_data     : [NUM_REQS*DATAW]    per-requester payload
//   req_rd/rs1/rs2/rs3 : [NUM_REQS*NR_BITS] register indices
//   req_wb       : [NUM_REQS]          instruction writes rd
//   wb_valid     : writeback strobe
//   wb_eop       : writeback is the last beat; only then is rd released
//   wb_req       : [clog2(NUM_REQS)]   requester owning the released register
//   wb_rd        : [NR_BITS]           released register index
//   out_valid    : output register holds an instruction
//   out_ready    : downstream accepts the held instruction
//   out_data     : [DATAW]             granted payload
//   out_req      : [clog2(NUM_REQS)]   granted requester
//   stall_cycles : [32] saturating count of cycles with requests and no grant
//   err_bad_wb   : sticky, set when a release targets a non-busy register
// ---------------------------------------------------------------------------
module vx_scb_issue_arb #(
    parameter int NUM_REQS = 4,
    parameter int NUM_REGS = 64,
    parameter int DATAW    = 64,
    localparam int NR_BITS = $clog2(NUM_REGS),
    localparam int RQ_BITS = $clog2(NUM_REQS)
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [NUM_REQS-1:0]         req_valid,
    output logic [NUM_REQS-1:0]         req_ready,
    input  logic [NUM_REQS*DATAW-1:0]   req_data,
    input  logic [NUM_REQS*NR_BITS-1:0] req_rd,
    input  logic [NUM_REQS*NR_BITS-1:0] req_rs1,
    input  logic [NUM_REQS*NR_BITS-1:0] req_rs2,
    input  logic [NUM_REQS*NR_BITS-1:0] req_rs3,
    input  logic [NUM_REQS-1:0]         req_wb,

    input  logic                        wb_valid,
    input  logic                        wb_eop,
    input  logic [RQ_BITS-1:0]          wb_req,
    input  logic [NR_BITS-1:0]          wb_rd,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATAW-1:0]            out_data,
    output logic [RQ_BITS-1:0]          out_req,

    output logic [31:0]                 stall_cycles,
    output logic                        err_bad_wb
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NUM_REQS-1:0][NUM_REGS-1:0] r_inuse;
    logic [RQ_BITS-1:0]                r_rr_ptr;
    logic                              r_out_valid;
    logic [DATAW-1:0]                  r_out_data;
    logic [RQ_BITS-1:0]                r_out_req;
    logic [31:0]                       r_stall_cycles;
    logic                              r_err_bad_wb;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic [NUM_REQS-1:0] w_eligible;
    logic [RQ_BITS-1:0]  w_scan_idx [NUM_REQS];
    logic                w_found;
    logic [RQ_BITS-1:0]  w_grant_idx;
    logic                w_can_accept;
    logic                w_grant;
    logic [NR_BITS-1:0]  w_set_rd;
    logic                w_set;
    logic                w_release;
    logic                w_bad_release;
    logic                w_stall;

    // Hazard check per requester. All four indices are always checked,
    // including rd, so that a second write to a pending register waits
    // (WAW) as well as reads of it (RAW). The check uses only the registered
    // busy bits. A writeback arriving this cycle therefore unblocks the
    // requester only on the following cycle.
    for (genvar r = 0; r < NUM_REQS; r++) begin : g_req
        logic [NR_BITS-1:0] w_rd;
        logic [NR_BITS-1:0] w_rs1;
        logic [NR_BITS-1:0] w_rs2;
        logic [NR_BITS-1:0] w_rs3;

        assign w_rd  = req_rd [r*NR_BITS +: NR_BITS];
        assign w_rs1 = req_rs1[r*NR_BITS +: NR_BITS];
        assign w_rs2 = req_rs2[r*NR_BITS +: NR_BITS];
        assign w_rs3 = req_rs3[r*NR_BITS +: NR_BITS];

        assign w_eligible[r] = req_valid[r]
                             & ~r_inuse[r][w_rd]
                             & ~r_inuse[r][w_rs1]
                             & ~r_inuse[r][w_rs2]
                             & ~r_inuse[r][w_rs3];
    end

    // Scan order starts at the round-robin pointer. NUM_REQS is a power of
    // two, so the modulo wrap is the natural truncation of the sum.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_scan
        assign w_scan_idx[i] = r_rr_ptr + RQ_BITS'(i);
    end

    // The first eligible requester in scan order wins.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!w_found && w_eligible[w_scan_idx[i]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan_idx[i];
            end
        end
    end

    // The single output register can take a new entry when it is empty, or
    // when its current entry leaves this cycle. Grants are suppressed while
    // reset is held. Otherwise req_ready could pulse during an asynchronous
    // reset, while the state is being cleared.
    assign w_can_accept = ~r_out_valid | out_ready;
    assign w_grant      = w_found & w_can_accept & ~reset;

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    // Busy-bit set from the winner and release from writeback.
    assign w_set_rd      = req_rd[w_grant_idx*NR_BITS +: NR_BITS];
    assign w_set         = w_grant & req_wb[w_grant_idx];
    assign w_release     = wb_valid & wb_eop;
    assign w_bad_release = w_release & ~r_inuse[wb_req][wb_rd];

    assign w_stall = (|req_valid) & ~w_grant;

    // -----------------------------------------------------------------------
    // Output register and round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_req   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= req_data[w_grant_idx*DATAW +: DATAW];
                r_out_req   <= w_grant_idx;
                r_rr_ptr    <= w_grant_idx + 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard busy bits
    // -----------------------------------------------------------------------
    // The set is written after the clear. When both target the same bit, the
    // later non-blocking assignment takes effect, so the new owner keeps the
    // register busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inuse <= '0;
        end else begin
            if (w_release) begin
                r_inuse[wb_req][wb_rd] <= 1'b0;
            end
            if (w_set) begin
                r_inuse[w_grant_idx][w_set_rd] <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Status: stall counter (saturating) and sticky bad-release flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_err_bad_wb   <= 1'b0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_bad_release) begin
                r_err_bad_wb <= 1'b1;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_req      = r_out_req;
    assign stall_cycles = r_stall_cycles;
    assign err_bad_wb   = r_err_bad_wb;

endmodule
